// File: rtl/xfer_pkg.sv
// Shared types and defaults for the two-client SDRAM transfer arbiter.
package xfer_pkg;

  localparam int unsigned ADDRESSWIDTH_DEFAULT = 8;
  localparam int unsigned TIMEOUT_DEFAULT      = 1023;
  localparam int unsigned WDOG_W               = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    BUSY     = 2'd2,
    COMPLETE = 2'd3
  } state_t;

  // Client index to one-hot grant/done vector.
  function automatic logic [1:0] client_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin selector: on contention the client not granted last wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/xfer_arbiter.sv
// Arbitrates two clients onto one SDRAM read/write master pair, with
// one-shot go, watchdog abort and per-client completion pulses.
module xfer_arbiter
  import xfer_pkg::*;
#(
  parameter int unsigned ADDRESSWIDTH = ADDRESSWIDTH_DEFAULT,
  parameter int unsigned TIMEOUT      = TIMEOUT_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req0,
  input  logic                    req1,
  input  logic                    rw0,
  input  logic                    rw1,
  input  logic [ADDRESSWIDTH-1:0] base0,
  input  logic [ADDRESSWIDTH-1:0] base1,
  input  logic [ADDRESSWIDTH-1:0] len0,
  input  logic [ADDRESSWIDTH-1:0] len1,
  input  logic                    fixed0,
  input  logic                    fixed1,
  output logic [1:0]              gnt,
  output logic                    done0,
  output logic                    done1,
  output logic                    err,
  output logic                    ctl_wr_go,
  output logic                    ctl_wr_fixed_location,
  output logic [ADDRESSWIDTH-1:0] ctl_wr_addr_base,
  output logic [ADDRESSWIDTH-1:0] ctl_wr_length,
  input  logic                    ctl_wr_done,
  output logic                    ctl_rd_go,
  output logic                    ctl_rd_fixed_location,
  output logic [ADDRESSWIDTH-1:0] ctl_rd_addr_base,
  output logic [ADDRESSWIDTH-1:0] ctl_rd_length,
  input  logic                    ctl_rd_done
);

  localparam int unsigned AW = ADDRESSWIDTH;

  state_t            state_q, state_nx;
  logic [1:0]        gnt_nx;
  logic [1:0]        done_q, done_nx;
  logic              err_nx;
  logic              wr_go_nx, rd_go_nx;
  logic              rw_q, rw_nx;
  logic              last_q, last_nx;
  logic [WDOG_W-1:0] wdog_q, wdog_nx, wdog_inc;
  logic              wr_fixed_nx, rd_fixed_nx;
  logic [AW-1:0]     wr_base_nx, wr_len_nx, rd_base_nx, rd_len_nx;

  logic [1:0]        arb_gnt;
  logic              sel;
  logic              sel_rw, sel_fixed;
  logic [AW-1:0]     sel_base, sel_len;
  logic              act_done;

  rr_arb2 u_rr_arb2 (
    .req  ({req1, req0}),
    .last (last_q),
    .gnt  (arb_gnt)
  );

  assign sel       = arb_gnt[1];
  assign sel_rw    = sel ? rw1    : rw0;
  assign sel_fixed = sel ? fixed1 : fixed0;
  assign sel_base  = sel ? base1  : base0;
  assign sel_len   = sel ? len1   : len0;
  assign wdog_inc  = wdog_q + WDOG_W'(1);

  // Only the direction in flight may complete the transfer.
  assign act_done  = rw_q ? ctl_wr_done : ctl_rd_done;

  assign done0 = done_q[0];
  assign done1 = done_q[1];

  always_comb begin
    state_nx    = state_q;
    gnt_nx      = gnt;
    done_nx     = 2'b00;
    err_nx      = 1'b0;
    wr_go_nx    = 1'b0;
    rd_go_nx    = 1'b0;
    rw_nx       = rw_q;
    last_nx     = last_q;
    wdog_nx     = wdog_q;
    wr_fixed_nx = ctl_wr_fixed_location;
    wr_base_nx  = ctl_wr_addr_base;
    wr_len_nx   = ctl_wr_length;
    rd_fixed_nx = ctl_rd_fixed_location;
    rd_base_nx  = ctl_rd_addr_base;
    rd_len_nx   = ctl_rd_length;

    case (state_q)
      IDLE: begin
        wdog_nx = '0;
        if (arb_gnt != 2'b00) begin
          gnt_nx = arb_gnt;
          rw_nx  = sel_rw;
          if (sel_rw) begin
            wr_fixed_nx = sel_fixed;
            wr_base_nx  = sel_base;
            wr_len_nx   = sel_len;
          end else begin
            rd_fixed_nx = sel_fixed;
            rd_base_nx  = sel_base;
            rd_len_nx   = sel_len;
          end
          // Zero-length requests complete without touching the masters.
          if (sel_len == '0) begin
            state_nx = COMPLETE;
            done_nx  = client_onehot(sel);
          end else begin
            state_nx = ISSUE;
          end
        end
      end

      ISSUE: begin
        wr_go_nx = rw_q;
        rd_go_nx = ~rw_q;
        wdog_nx  = '0;
        state_nx = BUSY;
      end

      BUSY: begin
        // A done level still present while go is out belongs to the previous job.
        if (act_done && !(ctl_wr_go || ctl_rd_go)) begin
          state_nx = COMPLETE;
          done_nx  = gnt;
        end else if (wdog_inc == WDOG_W'(TIMEOUT)) begin
          state_nx = COMPLETE;
          done_nx  = gnt;
          err_nx   = 1'b1;
        end else begin
          wdog_nx = wdog_inc;
        end
      end

      COMPLETE: begin
        state_nx    = IDLE;
        gnt_nx      = 2'b00;
        rw_nx       = 1'b0;
        last_nx     = gnt[1];
        wdog_nx     = '0;
        wr_fixed_nx = 1'b0;
        wr_base_nx  = '0;
        wr_len_nx   = '0;
        rd_fixed_nx = 1'b0;
        rd_base_nx  = '0;
        rd_len_nx   = '0;
      end

      default: state_nx = IDLE;
    endcase
  end

  // last_q resets to client 1 so that client 0 wins the first contention.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q               <= IDLE;
      gnt                   <= 2'b00;
      done_q                <= 2'b00;
      err                   <= 1'b0;
      ctl_wr_go             <= 1'b0;
      ctl_rd_go             <= 1'b0;
      rw_q                  <= 1'b0;
      last_q                <= 1'b1;
      wdog_q                <= '0;
      ctl_wr_fixed_location <= 1'b0;
      ctl_wr_addr_base      <= '0;
      ctl_wr_length         <= '0;
      ctl_rd_fixed_location <= 1'b0;
      ctl_rd_addr_base      <= '0;
      ctl_rd_length         <= '0;
    end else begin
      state_q               <= state_nx;
      gnt                   <= gnt_nx;
      done_q                <= done_nx;
      err                   <= err_nx;
      ctl_wr_go             <= wr_go_nx;
      ctl_rd_go             <= rd_go_nx;
      rw_q                  <= rw_nx;
      last_q                <= last_nx;
      wdog_q                <= wdog_nx;
      ctl_wr_fixed_location <= wr_fixed_nx;
      ctl_wr_addr_base      <= wr_base_nx;
      ctl_wr_length         <= wr_len_nx;
      ctl_rd_fixed_location <= rd_fixed_nx;
      ctl_rd_addr_base      <= rd_base_nx;
      ctl_rd_length         <= rd_len_nx;
    end
  end

endmodule

// File: doc/xfer_arbiter.md
XFER_ARBITER -- requirements
Module: xfer_arbiter

Interface
REQ-001 The block SHALL have parameter ADDRESSWIDTH, default 8, the width of base and length fields.
REQ-002 The block SHALL have parameter TIMEOUT, default 1023, the maximum BUSY cycles before abort.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low (clk, reset).
REQ-004 Port clk  input  1  system clock; all state on rising edge.
REQ-005 Port reset  input  1  asynchronous active-low reset.
REQ-006 Ports req0/req1  input  1  client transfer request, level, held until doneN.
REQ-007 Ports rw0/rw1  input  1  client direction, 1=write to SDRAM, 0=read.
REQ-008 Ports base0/base1, len0/len1  input  ADDRESSWIDTH  client start address and byte length.
REQ-009 Ports fixed0/fixed1  input  1  client fixed-location flag.
REQ-010 Ports gnt  output  2  one-hot grant, selects the client owning the master user ports.
REQ-011 Ports done0/done1  output  1  one-cycle completion pulse to client.
REQ-012 Port err  output  1  one-cycle pulse on timeout abort.
REQ-013 Ports ctl_wr_go, ctl_wr_fixed_location, ctl_wr_addr_base, ctl_wr_length  output  1/1/AW/AW  write master control.
REQ-014 Port ctl_wr_done  input  1  write master done level.
REQ-015 Ports ctl_rd_go, ctl_rd_fixed_location, ctl_rd_addr_base, ctl_rd_length  output  1/1/AW/AW  read master control.
REQ-016 Port ctl_rd_done  input  1  read master done level.

Function
REQ-017 The FSM SHALL have states IDLE, ISSUE, BUSY, COMPLETE.
REQ-018 IDLE: with any reqN high, the FSM SHALL latch the winning client's rw/base/len/fixed, set gnt, and go to ISSUE next cycle.
REQ-019 Arbitration SHALL be round-robin: on simultaneous requests, the client not granted last wins; after reset, client 0 has priority.
REQ-020 ISSUE: ctl_wr_go (rw=1) or ctl_rd_go (rw=0) SHALL be high for exactly one cycle, then BUSY.
REQ-021 Control address/length/fixed outputs SHALL hold latched values from ISSUE until COMPLETE exits, and be zero otherwise.
REQ-022 A request with len=0 SHALL skip ISSUE/BUSY, going IDLE->COMPLETE with no go pulse.
REQ-023 BUSY: the FSM SHALL sample only the done of the active direction; done high -> COMPLETE; other-direction done is ignored.
REQ-024 BUSY: a 16-bit watchdog SHALL count from 0; reaching TIMEOUT SHALL pulse err and go to COMPLETE.
REQ-025 COMPLETE: doneN of the granted client SHALL pulse one cycle, gnt SHALL clear next cycle, last-grant SHALL update, FSM returns to IDLE.
REQ-026 A client dropping reqN mid-transfer SHALL NOT abort it; done still pulses.
REQ-027 Minimum request-to-go latency SHALL be 2 cycles; back-to-back grants SHALL have at least one IDLE cycle between them.

Reset
REQ-028 On reset low, state=IDLE, gnt=0, all go/done/err=0, control fields=0, watchdog=0, priority=client 0, immediately and asynchronously.
REQ-029 Reset mid-transfer SHALL abandon the transfer without any done or err pulse.

Structure
REQ-030 The state enum and default TIMEOUT SHALL live in shared package xfer_pkg.
REQ-031 Round-robin selection SHALL be sub-module rr_arb2 (req[1:0], last, gnt[1:0]); everything else is flat.

Verification
REQ-032 req0 only, rw0=1, base0=8'h10, len0=8'h20 -> ctl_wr_go single pulse 2 cycles later with base 8'h10/len 8'h20; ctl_wr_done -> done0 pulse.
REQ-033 req0 and req1 asserted together twice -> grants client 0 then client 1, never two grants at once.
REQ-034 len1=0, rw1=0 -> done1 pulses with no ctl_rd_go ever asserted.
REQ-035 Read transfer, ctl_rd_done held low, TIMEOUT=15 -> err pulse exactly 15 cycles into BUSY, then done pulse, FSM returns to IDLE.
REQ-036 Write in BUSY, ctl_rd_done pulsed -> no completion; subsequent ctl_wr_done completes.
REQ-037 Reset asserted during BUSY -> all outputs zero same cycle, no done/err, next req0 granted normally.
